// File: rtl/mxctrl_pkg.sv
// Shared types for the serial-to-byte deserializer: FSM states, byte-entry record
// and the trailing-byte padding helper.
package mxctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam int GAP_CYCLES_DEF = 8;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic [2:0] pad;
   } byte_entry_t;

   // Moves k received bits so the first one lands on the byte's first-bit position.
   function automatic logic [7:0] pad_byte(input logic [7:0] sr, input logic [2:0] k,
                                           input bit msb_first);
      logic [2:0] sh;
      sh = 3'd0 - k;
      return msb_first ? (sr << sh) : (sr >> sh);
   endfunction

endpackage

// File: rtl/module1to8_if.sv
// Serial bit stream in, byte stream out with valid/ready, last and pad info.
interface module1to8_if;
   logic       i_data_in;
   logic       i_data_vald;
   logic [7:0] o_byte;
   logic       o_byte_vald;
   logic       i_byte_rdy;
   logic       o_byte_last;
   logic [2:0] o_pad_bits;

   modport slave (
      input  i_data_in, i_data_vald, i_byte_rdy,
      output o_byte, o_byte_vald, o_byte_last, o_pad_bits
   );

   modport master (
      output i_data_in, i_data_vald, i_byte_rdy,
      input  o_byte, o_byte_vald, o_byte_last, o_pad_bits
   );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head data is readable the cycle after a write.
module sync_fifo_fwft #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic             do_wr, do_rd;

   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign do_rd = rd_en && !empty;
   // A write into a full FIFO is still taken when the head leaves in the same cycle.
   assign do_wr = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_reg[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_wr) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_rd) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
   end
endmodule

// File: rtl/module1to8.sv
// Serial-to-byte deserializer: packs a gated bit stream into bytes, detects frame end
// from a valid-low gap, pads a trailing partial byte and buffers bytes in an FWFT FIFO.
module module1to8
   import mxctrl_pkg::*;
#(
   parameter int GAP_CYCLES = GAP_CYCLES_DEF,
   parameter int FIFO_DEPTH = 4,
   parameter int MSB_FIRST  = 1
) (
   input  logic             clk20m,
   input  logic             rst,
   module1to8_if.slave      bus,
   output logic             o_overflow,
   output logic [15:0]      o_frame_cnt
);
   state_t      state_reg, state_next;
   logic [7:0]  shift_reg, shift_next, shifted;
   logic [2:0]  bit_cnt_reg, bit_cnt_next;
   logic [3:0]  gap_cnt_reg, gap_cnt_next;
   byte_entry_t pend_reg, pend_next, push_entry, head;
   logic        pend_vld_reg, pend_vld_next;
   logic        overflow_reg, overflow_next;
   logic [15:0] frame_cnt_reg, frame_cnt_next;
   logic        push, pop, fifo_full, fifo_empty;
   logic [11:0] fifo_rd_data;

   assign shifted = (MSB_FIRST != 0) ? {shift_reg[6:0], bus.i_data_in}
                                     : {bus.i_data_in, shift_reg[7:1]};
   assign pop = !fifo_empty && bus.i_byte_rdy;

   always_comb begin
      state_next     = state_reg;
      shift_next     = shift_reg;
      bit_cnt_next   = bit_cnt_reg;
      gap_cnt_next   = gap_cnt_reg;
      pend_next      = pend_reg;
      pend_vld_next  = pend_vld_reg;
      overflow_next  = overflow_reg;
      frame_cnt_next = frame_cnt_reg;
      push           = 1'b0;
      push_entry     = pend_reg;

      // Bit acceptance is identical in every state; bit_cnt is 0 in IDLE and FLUSH.
      if (bus.i_data_vald) begin
         shift_next   = shifted;
         bit_cnt_next = bit_cnt_reg + 3'd1;
         gap_cnt_next = 4'd0;
         if (bit_cnt_reg == 3'd7) begin
            push          = pend_vld_reg;
            pend_next     = '{data: shifted, last: 1'b0, pad: 3'd0};
            pend_vld_next = 1'b1;
         end
      end

      case (state_reg)
         ST_IDLE: begin
            if (bus.i_data_vald) state_next = ST_RECV;
         end
         ST_RECV: begin
            if (!bus.i_data_vald) begin
               if (gap_cnt_reg == 4'(GAP_CYCLES - 1)) begin
                  gap_cnt_next = 4'd0;
                  if (bit_cnt_reg == 3'd0) begin
                     push           = pend_vld_reg;
                     push_entry     = '{data: pend_reg.data, last: 1'b1, pad: 3'd0};
                     pend_vld_next  = 1'b0;
                     frame_cnt_next = frame_cnt_reg + 16'd1;
                     state_next     = ST_IDLE;
                  end else begin
                     push          = pend_vld_reg;
                     pend_next     = '{data: pad_byte(shift_reg, bit_cnt_reg, MSB_FIRST != 0),
                                       last: 1'b1, pad: 3'd0 - bit_cnt_reg};
                     pend_vld_next = 1'b1;
                     shift_next    = 8'd0;
                     bit_cnt_next  = 3'd0;
                     state_next    = ST_FLUSH;
                  end
               end else begin
                  gap_cnt_next = gap_cnt_reg + 4'd1;
               end
            end
         end
         ST_FLUSH: begin
            push           = pend_vld_reg;
            pend_vld_next  = 1'b0;
            frame_cnt_next = frame_cnt_reg + 16'd1;
            state_next     = bus.i_data_vald ? ST_RECV : ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase

      if (push && fifo_full && !pop) overflow_next = 1'b1;
   end

   always_ff @(posedge clk20m) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         shift_reg     <= 8'd0;
         bit_cnt_reg   <= 3'd0;
         gap_cnt_reg   <= 4'd0;
         pend_reg      <= '0;
         pend_vld_reg  <= 1'b0;
         overflow_reg  <= 1'b0;
         frame_cnt_reg <= 16'd0;
      end else begin
         state_reg     <= state_next;
         shift_reg     <= shift_next;
         bit_cnt_reg   <= bit_cnt_next;
         gap_cnt_reg   <= gap_cnt_next;
         pend_reg      <= pend_next;
         pend_vld_reg  <= pend_vld_next;
         overflow_reg  <= overflow_next;
         frame_cnt_reg <= frame_cnt_next;
      end
   end

   sync_fifo_fwft #(
      .WIDTH ($bits(byte_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk20m),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (push_entry),
      .rd_en   (bus.i_byte_rdy),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Head is masked while empty so the outputs read zero rather than stale RAM.
   assign head            = fifo_empty ? '0 : byte_entry_t'(fifo_rd_data);
   assign bus.o_byte      = head.data;
   assign bus.o_byte_last = head.last;
   assign bus.o_pad_bits  = head.pad;
   assign bus.o_byte_vald = !fifo_empty;
   assign o_overflow      = overflow_reg;
   assign o_frame_cnt     = frame_cnt_reg;
endmodule

// File: tb/tb_module1to8.sv
// Directed bench for module1to8: table of single frames plus gap, latency,
// flush-cycle restart, overflow and mid-frame reset sequences.
module tb_module1to8;
   import mxctrl_pkg::*;

   localparam int GAP = 8;

   logic        clk20m = 1'b0;
   logic        rst    = 1'b1;
   logic        o_overflow;
   logic [15:0] o_frame_cnt;

   module1to8_if bus();

   module1to8 #(.GAP_CYCLES(GAP), .FIFO_DEPTH(4), .MSB_FIRST(1)) dut (
      .clk20m      (clk20m),
      .rst         (rst),
      .bus         (bus.slave),
      .o_overflow  (o_overflow),
      .o_frame_cnt (o_frame_cnt)
   );

   always #25 clk20m = ~clk20m;

   typedef struct {
      logic [15:0] bits;
      int          nbits;
      int          nexp;
      logic [11:0] e0;
      logic [11:0] e1;
   } vec_t;

   vec_t        vecs [6];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          exp_frames = 0;
   int          lat;
   logic [11:0] got_q [$];

   function automatic logic [11:0] ent(input logic [7:0] d, input logic l, input logic [2:0] p);
      return {d, l, p};
   endfunction

   always @(negedge clk20m) begin
      if (!rst && bus.o_byte_vald && bus.i_byte_rdy) begin
         got_q.push_back({bus.o_byte, bus.o_byte_last, bus.o_pad_bits});
         $display("byte 0x%02h last=%0d pad=%0d frames=%0d", bus.o_byte, bus.o_byte_last,
                  bus.o_pad_bits, o_frame_cnt);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk20m);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bus.i_data_in   = b;
      bus.i_data_vald = 1'b1;
      tick();
      bus.i_data_vald = 1'b0;
      bus.i_data_in   = 1'b0;
   endtask

   task automatic send_bits(input logic [15:0] v, input int n);
      for (int i = 0; i < n; i++) send_bit(v[15-i]);
   endtask

   task automatic idle(input int n);
      bus.i_data_vald = 1'b0;
      repeat (n) tick();
   endtask

   task automatic check_q(input string name, input int nexp, input logic [11:0] e0,
                          input logic [11:0] e1);
      check({name, " count"}, 32'(got_q.size()), 32'(nexp));
      if (nexp > 0 && got_q.size() > 0) check({name, " byte0"}, 32'(got_q[0]), 32'(e0));
      if (nexp > 1 && got_q.size() > 1) check({name, " byte1"}, 32'(got_q[1]), 32'(e1));
      check({name, " frames"}, 32'(o_frame_cnt), 32'(16'(exp_frames)));
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{16'hA53C, 16, 2, ent(8'hA5, 1'b0, 3'd0), ent(8'h3C, 1'b1, 3'd0)};
      vecs[1] = '{16'hB2E0, 11, 2, ent(8'hB2, 1'b0, 3'd0), ent(8'hE0, 1'b1, 3'd5)};
      vecs[2] = '{16'h8100,  8, 1, ent(8'h81, 1'b1, 3'd0), 12'h000};
      vecs[3] = '{16'hA000,  3, 1, ent(8'hA0, 1'b1, 3'd5), 12'h000};
      vecs[4] = '{16'h8000,  1, 1, ent(8'h80, 1'b1, 3'd7), 12'h000};
      vecs[5] = '{16'hFF80,  9, 2, ent(8'hFF, 1'b0, 3'd0), ent(8'h80, 1'b1, 3'd7)};

      bus.i_data_in   = 1'b0;
      bus.i_data_vald = 1'b0;
      bus.i_byte_rdy  = 1'b1;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset vald",  32'(bus.o_byte_vald), 32'd0);
      check("reset byte",  32'(bus.o_byte), 32'd0);
      check("reset last",  32'(bus.o_byte_last), 32'd0);
      check("reset pad",   32'(bus.o_pad_bits), 32'd0);
      check("reset ovf",   32'(o_overflow), 32'd0);
      check("reset frames", 32'(o_frame_cnt), 32'd0);

      for (int v = 0; v < 6; v++) begin
         got_q.delete();
         send_bits(vecs[v].bits, vecs[v].nbits);
         idle(GAP + 4);
         exp_frames++;
         check_q($sformatf("vec%0d", v), vecs[v].nexp, vecs[v].e0, vecs[v].e1);
      end

      // 5-cycle hole inside a byte does not end the frame
      got_q.delete();
      send_bits(16'hF000, 4); idle(5); send_bits(16'h0000, 4); idle(GAP + 4);
      exp_frames++;
      check_q("hole5", 1, ent(8'hF0, 1'b1, 3'd0), 12'h000);

      // GAP-1 idle cycles are still transparent
      got_q.delete();
      send_bits(16'hF000, 4); idle(GAP - 1); send_bits(16'h0000, 4); idle(GAP + 4);
      exp_frames++;
      check_q("hole_gap-1", 1, ent(8'hF0, 1'b1, 3'd0), 12'h000);

      // exactly GAP idle cycles splits into two padded frames
      got_q.delete();
      send_bits(16'hF000, 4); idle(GAP); send_bits(16'h0000, 4); idle(GAP + 4);
      exp_frames += 2;
      check_q("hole_gap", 2, ent(8'hF0, 1'b1, 3'd4), ent(8'h00, 1'b1, 3'd4));

      // latency from last bit: whole byte, then partial byte
      send_bits(16'h8100, 8);
      lat = 1;
      while (!bus.o_byte_vald && lat < 40) begin tick(); lat++; end
      check("latency full", 32'(lat), 32'(GAP + 1));
      idle(4);
      send_bits(16'hA000, 3);
      lat = 1;
      while (!bus.o_byte_vald && lat < 40) begin tick(); lat++; end
      check("latency partial", 32'(lat), 32'(GAP + 2));
      idle(4);
      exp_frames += 2;

      // new frame starting in the FLUSH cycle
      got_q.delete();
      send_bits(16'hA000, 3); idle(GAP); send_bits(16'hC300, 8); idle(GAP + 4);
      exp_frames += 2;
      check_q("flush_restart", 2, ent(8'hA0, 1'b1, 3'd5), ent(8'hC3, 1'b1, 3'd0));

      // overflow: six one-byte frames into a 4-deep FIFO with consumer stalled
      got_q.delete();
      bus.i_byte_rdy = 1'b0;
      for (int f = 1; f <= 6; f++) begin
         send_bits({8'(f), 8'h00}, 8);
         idle(GAP + 4);
      end
      exp_frames += 6;
      check("ovf sticky", 32'(o_overflow), 32'd1);
      check("ovf head vald", 32'(bus.o_byte_vald), 32'd1);
      check("ovf head byte", 32'(bus.o_byte), 32'h01);
      check("ovf frames", 32'(o_frame_cnt), 32'(16'(exp_frames)));
      bus.i_byte_rdy = 1'b1;
      idle(8);
      check("drain count", 32'(got_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (got_q.size() > i)
            check($sformatf("drain%0d", i), 32'(got_q[i]), 32'(ent(8'(i + 1), 1'b1, 3'd0)));
      end
      check("drain empty", 32'(bus.o_byte_vald), 32'd0);
      check("ovf still set", 32'(o_overflow), 32'd1);

      // reset mid-byte with two bytes buffered
      bus.i_byte_rdy = 1'b0;
      send_bits(16'h1100, 8); idle(GAP + 4);
      send_bits(16'h2200, 8); idle(GAP + 4);
      check("pre-rst vald", 32'(bus.o_byte_vald), 32'd1);
      send_bits(16'hA000, 3);
      rst = 1'b1;
      tick();
      check("rst vald",   32'(bus.o_byte_vald), 32'd0);
      check("rst byte",   32'(bus.o_byte), 32'd0);
      check("rst last",   32'(bus.o_byte_last), 32'd0);
      check("rst pad",    32'(bus.o_pad_bits), 32'd0);
      check("rst ovf",    32'(o_overflow), 32'd0);
      check("rst frames", 32'(o_frame_cnt), 32'd0);
      rst = 1'b0;
      bus.i_byte_rdy = 1'b1;
      got_q.delete();
      exp_frames = 0;
      tick();
      send_bits(16'h8100, 8); idle(GAP + 4);
      exp_frames++;
      check_q("post_rst", 1, ent(8'h81, 1'b1, 3'd0), 12'h000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
